// File: rtl/fp16_unpack_stage.sv
// fp16_unpack_stage: two-stage decode of IEEE-754 binary16 operands into
// sign, unbiased exponent and an 11-bit normalized significand with the
// hidden bit explicit. Subnormals are pre-normalized and special encodings
// are flagged so the multiplier never sees raw FP16 words.
//
// Handshake: a word moves across an interface on a rising clk edge where
// valid and ready are both high. A producer holds valid and its data
// steady until that edge. A stage loads when its downstream stage is
// empty or transferring out in the same cycle. in_ready depends
// combinationally on out_ready. No combinational path runs from in_valid
// to out_valid.
module fp16_unpack_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [6:0]       out_exp,
  output logic [10:0]      out_mant,
  output logic             out_zero,
  output logic             out_inf,
  output logic             out_nan,
  output logic             out_sub,
  output logic [CNT_W-1:0] sub_cnt,
  input  logic             cnt_clr
);

  // Stage A holds the raw fields, the class flags and the leading-zero count.
  logic       a_valid;
  logic       a_sign;
  logic [4:0] a_exp;
  logic [9:0] a_frac;
  logic       a_zero, a_sub, a_inf, a_nan;
  logic [3:0] a_lz;

  logic       a_advance;
  logic       in_fire;
  logic       in_exp_zero, in_exp_ones, in_frac_zero;
  logic [3:0] lz_next;
  logic [6:0] b_exp_next;
  logic [10:0] b_mant_next;

  assign a_advance    = !out_valid || out_ready;
  assign in_ready     = !a_valid || a_advance;
  assign in_fire      = in_valid && in_ready;
  assign in_exp_zero  = (in_data[14:10] == 5'd0);
  assign in_exp_ones  = (in_data[14:10] == 5'd31);
  assign in_frac_zero = (in_data[9:0] == 10'd0);

  // Leading-zero count of the fraction; the highest set bit wins.
  always_comb begin
    lz_next = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (in_data[i]) lz_next = 4'(9 - i);
    end
  end

  // Stage A: capture the word and classify it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_valid <= 1'b0;
      a_sign  <= 1'b0;
      a_exp   <= 5'd0;
      a_frac  <= 10'd0;
      a_zero  <= 1'b0;
      a_sub   <= 1'b0;
      a_inf   <= 1'b0;
      a_nan   <= 1'b0;
      a_lz    <= 4'd0;
    end else if (in_ready) begin
      a_valid <= in_valid;
      a_sign  <= in_data[15];
      a_exp   <= in_data[14:10];
      a_frac  <= in_data[9:0];
      a_zero  <= in_exp_zero && in_frac_zero;
      a_sub   <= in_exp_zero && !in_frac_zero;
      a_inf   <= in_exp_ones && in_frac_zero;
      a_nan   <= in_exp_ones && !in_frac_zero;
      a_lz    <= lz_next;
    end
  end

  // Normalization of the stage A word: subnormals are shifted so bit10 is
  // the leading one and their exponent drops by one per shifted position.
  always_comb begin
    b_mant_next = 11'd0;
    b_exp_next  = 7'd0;
    if (a_zero) begin
      b_mant_next = 11'd0;
      b_exp_next  = 7'd0;
    end else if (a_sub) begin
      b_mant_next = {a_frac, 1'b0} << a_lz;
      b_exp_next  = 7'h71 - {3'd0, a_lz};
    end else if (a_inf || a_nan) begin
      b_mant_next = {1'b1, a_frac};
      b_exp_next  = 7'd16;
    end else begin
      b_mant_next = {1'b1, a_frac};
      b_exp_next  = {2'd0, a_exp} - 7'd15;
    end
  end

  // Stage B: register the decoded result; holds while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_exp   <= 7'd0;
      out_mant  <= 11'd0;
      out_zero  <= 1'b0;
      out_inf   <= 1'b0;
      out_nan   <= 1'b0;
      out_sub   <= 1'b0;
    end else if (a_advance) begin
      out_valid <= a_valid;
      out_sign  <= a_sign;
      out_exp   <= b_exp_next;
      out_mant  <= b_mant_next;
      out_zero  <= a_zero;
      out_inf   <= a_inf;
      out_nan   <= a_nan;
      out_sub   <= a_sub;
    end
  end

  // Saturating count of subnormal words accepted at the input; clear wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sub_cnt <= '0;
    end else if (cnt_clr) begin
      sub_cnt <= '0;
    end else if (in_fire && in_exp_zero && !in_frac_zero && (sub_cnt != '1)) begin
      sub_cnt <= sub_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_fp16_unpack_stage.sv
// Bench for fp16_unpack_stage: directed cases, backpressure, reset
// mid-stream, counter saturation/clear and a randomized stream, all checked
// by a scoreboard against a value-level reference model.
module tb_fp16_unpack_stage;

  localparam int CNT_W = 2;
  localparam int RW    = 23;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [6:0]       out_exp;
  logic [10:0]      out_mant;
  logic             out_zero, out_inf, out_nan, out_sub;
  logic [CNT_W-1:0] sub_cnt;
  logic             cnt_clr;

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q[$];
  int            cnt_model = 0;
  logic          stall_prev = 1'b0;
  logic [RW-1:0] prev_vec = '0;
  logic [RW-1:0] out_vec;

  fp16_unpack_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant),
    .out_zero(out_zero), .out_inf(out_inf), .out_nan(out_nan),
    .out_sub(out_sub), .sub_cnt(sub_cnt), .cnt_clr(cnt_clr)
  );

  assign out_vec = {out_sign, out_exp, out_mant, out_zero, out_inf, out_nan, out_sub};

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: value-level decode {sign, exp, mant, zero, inf, nan, sub}.
  function automatic logic [RW-1:0] ref_model(input logic [15:0] d);
    int e, f, p, ex;
    logic [10:0] m;
    logic z, i, n, s;
    e = int'(d[14:10]);
    f = int'(d[9:0]);
    z = 0; i = 0; n = 0; s = 0; ex = 0; m = '0;
    if (e == 0 && f == 0) begin
      z = 1;
    end else if (e == 31) begin
      ex = 16;
      m = 11'(1024 + f);
      if (f == 0) i = 1; else n = 1;
    end else if (e == 0) begin
      // value = f * 2^-24; highest set bit p becomes the leading one.
      s = 1;
      p = 0;
      for (int k = 0; k < 10; k++) if (f >= (1 << k)) p = k;
      m = 11'(f << (10 - p));
      ex = p - 24;
    end else begin
      m = 11'(1024 + f);
      ex = e - 15;
    end
    return {d[15], 7'(ex), m, z, i, n, s};
  endfunction

  // Scoreboard / monitor: sampled on the falling edge, away from the
  // active edge. Queue size equals the number of words in flight.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      cnt_model = 0;
      stall_prev = 1'b0;
    end else begin
      check("in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || out_ready));
      check("sub_cnt", 32'(sub_cnt), 32'(cnt_model));
      if (stall_prev) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_vec), 32'(prev_vec));
      end
      if (out_valid && exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out: got %0h expected none at %0t", out_vec, $time);
      end else if (out_valid && out_ready) begin
        check("out_data", 32'(out_vec), 32'(exp_q.pop_front()));
      end
      stall_prev = out_valid && !out_ready;
      prev_vec = out_vec;
      if (cnt_clr) cnt_model = 0;
      else if (in_valid && in_ready && ref_model(in_data)[0] && cnt_model < 3) cnt_model++;
      if (in_valid && in_ready) exp_q.push_back(ref_model(in_data));
    end
  end

  // Driver: present one word, wait (bounded) for acceptance. Call at posedge+1.
  task automatic send(input logic [15:0] d);
    int guard;
    in_valid = 1'b1;
    in_data  = d;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no in_ready expected accept of %0h", d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    case ($urandom_range(0, 5))
      0: w[14:10] = 5'd0;
      1: w[14:10] = 5'd31;
      2: begin w[14:10] = 5'd0; w[9:0] = 10'd0; end
      3: w[9:0] = 10'd0;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    logic [15:0] dir_words[6];
    logic acc;
    int guard;
    dir_words = '{16'h3C00, 16'h0001, 16'h8200, 16'h7C00, 16'h7E00, 16'h8000};

    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; cnt_clr = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_vec", 32'(out_vec), 32'd0);
    check("rst_sub_cnt", 32'(sub_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    idle(2);
    rst = 1'b1;
    idle(1);

    // Latency: accepted at edge k, visible after edge k+1.
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'h3C00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_mant", 32'(out_mant), 32'h400);
    @(posedge clk); #1;
    idle(2);

    // Directed values, including subnormals and specials.
    for (int k = 0; k < 6; k++) send(dir_words[k]);
    idle(3);
    check("dir_sub_cnt", 32'(sub_cnt), 32'd2);

    // Backpressure: 4 words, output stalled, then released.
    out_ready = 1'b0;
    fork
      begin
        send(16'h3C00); send(16'h0003); send(16'hC500); send(16'h7C00);
      end
      begin
        idle(6);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_inflight", 32'(exp_q.size()), 32'd2);
        out_ready = 1'b1;
      end
    join
    idle(4);

    // Reset with both stages full.
    out_ready = 1'b0;
    send(16'h0004); send(16'h0010);
    @(negedge clk);
    check("full_before_rst", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_sub_cnt", 32'(sub_cnt), 32'd0);
    @(posedge clk); #1;
    idle(1);
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    idle(5);

    // Counter saturation and clear-wins-over-increment.
    cnt_clr = 1'b1; idle(1); cnt_clr = 1'b0;
    for (int k = 0; k < 5; k++) send(16'(k + 1));
    check("cnt_saturate", 32'(sub_cnt), 32'd3);
    cnt_clr = 1'b1;
    send(16'h0001);
    cnt_clr = 1'b0;
    check("cnt_clr_prio", 32'(sub_cnt), 32'd0);
    idle(3);

    // Randomized stream; valid held until accepted.
    in_valid = 1'b1; in_data = rand_word();
    for (int c = 0; c < 600; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr   = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = rand_word();
      end
    end
    in_valid = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;

    // Drain with a bounded wait.
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin idle(1); guard++; end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp16_unpack_stage.md
Name: fp16_unpack_stage

Overview:
- Input-side counterpart of the MAC output packer. It accepts IEEE-754 binary16 operands and decomposes each into sign, unbiased exponent and an 11-bit normalized significand (hidden bit explicit).
- Subnormals are pre-normalized, and special values are flagged so downstream multiply/align stages never handle raw FP16 encodings.
- Two-stage valid/ready pipeline with full backpressure. It sits between the operand fetch logic and the MAC Stage1 multiplier.

Parameters:
- CNT_W, 16, width of the saturating subnormal-event counter.

Ports:
- clk input 1 clock
- rst input 1 reset, asynchronous, active-low
- in_valid input 1 upstream word valid
- in_ready output 1 stage can accept a word this cycle
- in_data input 16 FP16 word {sign[15], exp[14:10], frac[9:0]}
- out_valid output 1 decoded result valid
- out_ready input 1 downstream accepts result
- out_sign output 1 sign bit
- out_exp output 7 unbiased exponent, two's complement
- out_mant output 11 normalized significand, bit10 = leading one
- out_zero output 1 operand is ±0
- out_inf output 1 operand is ±inf
- out_nan output 1 operand is NaN
- out_sub output 1 operand was subnormal
- sub_cnt output CNT_W saturating count of accepted subnormal words
- cnt_clr input 1 synchronous clear of sub_cnt

Behaviour:
- Reset (rst low, async): every pipeline register is 0.
  - out_valid=0; out_sign/out_exp/out_mant/flags=0; sub_cnt=0.
  - in_ready=1 once the pipeline is empty.
  - Reset mid-operation drops all in-flight words; no partial output appears.
- Pipeline, stage A (capture + classify):
  - Registers in_data together with class flags.
  - e==0 & f==0 → zero.
  - e==0 & f!=0 → sub.
  - e==31 & f==0 → inf.
  - e==31 & f!=0 → nan.
  - Otherwise → normal.
  - Also registers the leading-zero count lz (0..9) of f.
- Pipeline, stage B (normalize):
  - normal: mant={1,f}, exp=e-15 (range -14..+15).
  - sub: mant={f,1'b0}<<lz, so bit10=1; exp=-14-(lz+1) (range -15..-24).
  - zero: mant=0, exp=0.
  - inf/nan: mant={1,f}, exp=+16.
  - Exactly one of the zero/inf/nan/sub flags, or none, is set.
- Latency: 2 cycles from the in_valid&in_ready handshake to out_valid, when out_ready is held 1. Throughput is 1 word/cycle.
- Handshake:
  - A transfer occurs when valid&ready are both high at a clk edge.
  - Each stage advances when its downstream stage is empty or transferring that cycle.
  - in_ready = !A_valid | (!B_valid | out_ready).
  - in_ready is combinational on out_ready. No combinational path exists from in_valid to out_valid.
  - Outputs stay stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a transfer.
- Full condition: both stages valid and out_ready=0 → in_ready=0. No word is lost or duplicated.
- Simultaneous events: with both stages full and out_ready=1, B transfers out, A moves to B, and a new word is accepted, all in one cycle.
- sub_cnt:
  - Increments by 1 when a subnormal word is accepted at the input handshake.
  - Saturates at 2^CNT_W-1.
  - cnt_clr has priority over increment; with clear and increment in the same cycle, the result is 0.

Test Plan:
- Normal value: in_data=16'h3C00 (1.0), out_ready=1 → out_valid 2 cycles later; sign=0, exp=0, mant=11'h400, all flags 0.
- Subnormals:
  - 16'h0001 → exp=-24 (7'h68), mant=11'h400, sub=1, sub_cnt=1.
  - 16'h8200 → sign=1, exp=-15 (7'h71), mant=11'h400, sub=1.
- Specials:
  - 16'h7C00 → inf=1, exp=16.
  - 16'h7E00 → nan=1, exp=16.
  - 16'h8000 → zero=1, sign=1, mant=0.
- Backpressure: stream 4 words with out_ready=0 → in_ready falls after 2 accepts. Raise out_ready → all 4 words emerge in order, no loss or duplication, outputs stable while stalled.
- Reset mid-stream: assert rst with both stages full → out_valid=0 and sub_cnt=0 immediately (async). After release, in_ready=1 and no stale word appears.
- Counter: CNT_W=2, feed 5 subnormals → sub_cnt saturates at 3. Pulse cnt_clr together with a subnormal accept → sub_cnt=0.
